// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory port, redirect from execute and
// the decode-side valid/ready handshake.
interface fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output inst_valid, inst, inst_pc,
        input  inst_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  inst_valid, inst, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited request issue, in-order response
// buffer toward decode, and redirect flush with stale-response dropping.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    localparam int          AW  = $clog2(FIFO_DEPTH);
    localparam int          CW  = AW + 1;
    localparam int          SW  = AW + 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   r_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic          r_run;
    logic [31:0]   r_data [FIFO_DEPTH];
    logic [31:0]   r_tag  [FIFO_DEPTH];

    logic          w_valid;
    logic          w_pop;
    logic          w_push;
    logic          w_req;
    logic          w_fire;
    logic [SW-1:0] w_credit;
    logic [31:0]   w_push_pc;
    logic [31:0]   w_redirect_pc;

    assign w_valid       = (r_count != '0);
    assign w_pop         = w_valid & bus.inst_ready;
    assign w_push        = bus.imem_rvalid & (r_discard == '0) & ~bus.redirect_valid;
    // A slot freed by this cycle's pop can already back a new request.
    assign w_credit      = SW'(r_inflight) + SW'(r_count) - SW'(w_pop);
    assign w_req         = r_run & ~bus.redirect_valid & (w_credit < SW'(FIFO_DEPTH));
    assign w_fire        = w_req & bus.imem_gnt;
    // Once discard is zero every in-flight request is on the current path,
    // so the oldest one sits r_inflight words behind the PC.
    assign w_push_pc     = r_pc - (32'(r_inflight) << 2);
    assign w_redirect_pc = bus.redirect_pc & 32'hFFFF_FFFC;

    assign bus.imem_req   = w_req;
    assign bus.imem_addr  = r_pc;
    assign bus.inst_valid = w_valid;
    assign bus.inst       = w_valid ? r_data[r_rd_ptr] : NOP;
    assign bus.inst_pc    = w_valid ? r_tag[r_rd_ptr]  : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_inflight <= '0;
            r_discard  <= '0;
            r_run      <= 1'b0;
        end else begin
            r_run      <= 1'b1;
            r_inflight <= r_inflight + CW'(w_fire) - CW'(bus.imem_rvalid);
            if (bus.redirect_valid) begin
                r_pc      <= w_redirect_pc;
                r_discard <= r_inflight - CW'(bus.imem_rvalid);
            end else begin
                if (w_fire)
                    r_pc <= r_pc + 32'd4;
                if (bus.imem_rvalid && (r_discard != '0))
                    r_discard <= r_discard - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (bus.redirect_valid) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wr_ptr] <= bus.imem_rdata;
            r_tag[r_wr_ptr]  <= w_push_pc;
        end
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of decode.
- Holds the PC and issues word fetches on a req/gnt/rvalid instruction-memory port.
- Buffers returned words in an in-order FIFO and presents {inst, inst_pc} to decode with a valid/ready handshake.
- Accepts redirects from execute (branch/jump target), flushes wrong-path instructions and drops stale responses.

Parameters:
- RESET_PC, 32'h0000_0000: PC fetched first after reset.
- FIFO_DEPTH, 4: instruction buffer entries; also the maximum number of in-flight requests. Power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- redirect_valid  in  1  take redirect_pc this cycle.
- redirect_pc  in  32  new fetch target; bits [1:0] ignored (forced to 0).
- imem_req  out  1  fetch request.
- imem_addr  out  32  word address of the request (= pc).
- imem_gnt  in  1  request accepted; only meaningful when imem_req=1.
- imem_rvalid  in  1  response valid; responses return in request order, ≥1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  FIFO head valid to decode.
- inst  out  32  instruction to decode; 32'h0000_0013 (NOP) when inst_valid=0.
- inst_pc  out  32  PC of inst; 0 when inst_valid=0.
- inst_ready  in  1  decode accepts the head this cycle.

Behaviour:
- Reset (rst_n=0, async):
  - pc=RESET_PC; FIFO empty; inflight=0; discard=0.
  - imem_req=0, inst_valid=0, inst=NOP, inst_pc=0.
- State:
  - pc (32b).
  - inflight: granted, not yet responded, 0..FIFO_DEPTH.
  - discard: stale responses still to drop, ≤ inflight.
  - count: FIFO occupancy, 0..FIFO_DEPTH.
- Definitions: pop = inst_valid & inst_ready; push = imem_rvalid & (discard==0) & !redirect_valid.
- Issue:
  - imem_req = !redirect_valid & (inflight + count − pop < FIFO_DEPTH).
  - imem_req combinationally depends on inst_ready and redirect_valid.
  - imem_addr = pc.
  - On imem_req & imem_gnt: pc <= pc + 4 (wraps mod 2^32); inflight increments.
- Response:
  - imem_rvalid decrements inflight.
  - If discard>0: word is dropped and discard decrements.
  - Otherwise the word is pushed with the PC of its request. A tag FIFO of request PCs, or pc minus in-flight offset, tracks that PC.
- FIFO output:
  - Registered; a word pushed in cycle N is visible at inst_valid in cycle N+1 at earliest.
  - Push and pop in the same cycle are both allowed, including at count=FIFO_DEPTH.
  - Push never overflows: this is guaranteed by the credit rule above.
- Redirect (redirect_valid=1 in cycle N):
  - pc <= {redirect_pc[31:2],2'b00}.
  - FIFO flushed; inst_valid=0 in N+1.
  - discard <= inflight − imem_rvalid (all older in-flight requests become stale).
  - An rvalid in cycle N is dropped.
  - imem_req=0 in cycle N; first new-path request in N+1.
  - A pop in cycle N is ignored (flushed).
  - Back-to-back redirects: the later one wins; discard accumulates correctly.
- Latency, redirect to inst_valid with 1-cycle memory (gnt same cycle, rvalid next): redirect N → req N+1 → rvalid N+2 → inst_valid N+3.
- Throughput: 1 instruction/cycle sustained with 1-cycle memory and inst_ready=1.
- Backpressure: inst_ready=0 holds inst/inst_pc stable. Fetch stops when inflight+count reaches FIFO_DEPTH.
- Reset mid-operation: all state cleared immediately. Responses arriving after rst_n deasserts that belong to pre-reset requests are a system error; the memory is reset together with this block.

Test Plan:
- Reset release, memory returns pc>>2 as data, inst_ready=1:
  - imem_addr sequence 0,4,8,C.
  - inst_valid first high 2 cycles after first gnt.
  - inst_pc 0,4,8 consecutive every cycle.
- inst_ready=0 for 10 cycles:
  - count saturates at 4, imem_req=0, inst/inst_pc stable.
  - After release, 4 buffered words drain in order, then fetch resumes without gaps or duplicates.
- Redirect to 32'h0000_0102 with 2 requests in flight:
  - imem_addr next cycle = 32'h0000_0100.
  - Both old responses dropped.
  - First inst_pc out = 32'h100.
- Redirect in the same cycle as imem_rvalid and pop:
  - Response dropped, FIFO empty next cycle.
  - Next inst_pc = redirect target.
- Wrap: RESET_PC=32'hFFFF_FFF8 → imem_addr FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Memory with variable latency (1–3 cycles, random gnt stalls):
  - inst sequence matches a reference model of addresses.
  - No overflow; inflight never exceeds 4.
